fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupled instruction-fetch front end for the pipelined core. It issues sequential word fetches to the synchronous instruction BRAM every cycle and applies the core's static branch prediction to returned words. Fetched instructions are buffered in a parametrised FIFO so that decode stalls do not stall fetch. A redirect from execute flushes all buffered and in-flight work.

## Interface
- ADDR_W, 17: instruction BRAM word-address width; byte PC bits [ADDR_W+1:2] form the address.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state changes on posedge.
- rstn  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  mispredict/exception redirect from execute.
- redirect_pc  in  32  redirect target; must be word-aligned.
- mem_en  out  1  fetch issued this cycle.
- inst_addr  out  ADDR_W  word address of the issued fetch.
- inst_data  in  32  BRAM read data, valid exactly one cycle after mem_en.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  32  PC of head instruction.
- out_inst  out  32  head instruction word.
- out_pred_taken  out  1  head was predicted taken.
- out_pred_target  out  32  predicted target; equals out_pc+4 when not taken.

## Operation
- State: fetch PC fpc; one in-flight slot {inflight, inflight_pc}; FIFO of DEPTH entries {pc, inst, pred_taken, pred_target}; rd/wr pointers; count (0..DEPTH).
- Issue condition: !redirect_valid && !(return is predicted taken) && (count + inflight < DEPTH). Pops in the same cycle are not credited. On issue: mem_en=1, inst_addr=fpc[ADDR_W+1:2], inflight<=1, inflight_pc<=fpc, fpc<=fpc+4 (mod 2^32).
- Return: when inflight is 1, inst_data is taken this cycle. A word of 32'hffff_ffff is replaced by 32'h0000_0000 (NOP). The word is pushed with pc=inflight_pc. inflight clears unless a new issue occurs.
- Prediction on the pushed word w at pc p:
  - w[31:27]==5'b00001 (J/JAL): taken; target {4'b0000, w[25:0], 2'b00}.
  - w[31:26]==6'b110010 (BC): taken; target p + {4'b0000, w[25:0], 2'b00}.
  - w[31:27]==5'b00010 with w[15]==1 (backward BEQ/BNE): taken; target p + {{14{1'b1}}, w[15:0], 2'b00}.
  - Otherwise not taken; target p+4.
- Predicted-taken return: fpc<=target and no issue this cycle, giving exactly one bubble. A sequential fetch is never in flight at that point, so no squash is needed.
- Redirect (highest priority): count<=0, pointers<=0, inflight<=0, and any returning data this cycle is discarded. fpc<=redirect_pc, no issue this cycle, and a pop in the same cycle is ignored.
- Pop: out_valid && out_ready advances rd pointer. A simultaneous push and pop leaves count unchanged. The capacity rule guarantees a push never meets a full queue.
- Outputs are driven from the head entry. out_valid = (count != 0).

## Timing
- Reset values (asynchronous): fpc=RESET_PC, inflight=0, count=0, pointers=0. Outputs: out_valid=0, mem_en=0, inst_addr=0, out_pc/out_inst/out_pred_target=0, out_pred_taken=0.
- After reset release: first issue in cycle 0, data returns in cycle 1, out_valid=1 in cycle 2.
- Redirect asserted in cycle r: issue at redirect_pc in r+1, out_valid in r+3 at the earliest.
- Steady state with out_ready=1: one instruction per cycle. Each predicted-taken branch costs one bubble.
- Pointer wrap: modulo DEPTH. fpc and target arithmetic wrap modulo 2^32.
- With out_ready=0, fetch stops once count+inflight reaches DEPTH. It resumes the cycle after the first pop.
- rstn asserted mid-operation clears all state immediately. Contents of an in-flight return are dropped.

## Test plan
- Reset release, RESET_PC=0, BRAM[i]=i+1, out_ready=1 -> out_pc 0,4,8,… in consecutive cycles from cycle 2; out_inst 1,2,3,….
- BRAM[2]=32'h0800_0010 (J) at pc 8 -> entry pc 8 with pred_taken=1 and pred_target 0x40. Next entry is pc 0x40 after one bubble, and pc 0xC never appears.
- BRAM[5]=32'h1000_FFFE (backward BEQ) at pc 0x14 -> pred_target 0x0C. The same opcode with imm 0x0002 gives pred_taken=0 and pred_target 0x18.
- out_ready=0 from reset -> mem_en stops after DEPTH issues, count=DEPTH, and out_pc stays 0. Raising out_ready drains 0,4,8,12 and then continues at 16.
- Redirect to 0x100 while the queue is full, a fetch is in flight, and out_ready=1 -> next out_valid entry has pc 0x100. No stale entry is popped, and the redirect-cycle pop is ignored.
- BRAM word 32'hffff_ffff -> out_inst 0. rstn pulsed low mid-stream -> out_valid=0 asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: redirect input, instruction BRAM port and decode-side handshake.
// The master modport is the fetch_queue view; slave is the surrounding core/BRAM view.
interface fetch_queue_if #(
    parameter int ADDR_W = 17
);
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              mem_en;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic              out_pred_taken;
    logic [31:0]       out_pred_target;

    modport master (
        input  redirect_valid, redirect_pc, inst_data, out_ready,
        output mem_en, inst_addr, out_valid, out_pc, out_inst,
               out_pred_taken, out_pred_target
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_data, out_ready,
        input  mem_en, inst_addr, out_valid, out_pc, out_inst,
               out_pred_taken, out_pred_target
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential BRAM fetches, static branch prediction on
// returned words, and a small FIFO so decode stalls do not back up into fetch.
module fetch_queue #(
    parameter int          ADDR_W   = 17,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rstn,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0] fpc;
    logic        inflight;
    logic [31:0] inflight_pc;

    logic [31:0] pc_q     [DEPTH];
    logic [31:0] inst_q   [DEPTH];
    logic        taken_q  [DEPTH];
    logic [31:0] target_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [31:0] ret_word;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [PW+1:0] occupancy;
    logic        ret_taken;
    logic        issue;
    logic        push;
    logic        pop;
    logic        mem_en;
    logic        head_valid;

    // All-ones words come back from unprogrammed BRAM and are fetched as NOPs.
    always_comb begin
        ret_word    = (bus.inst_data == 32'hffff_ffff) ? 32'h0000_0000 : bus.inst_data;
        pred_taken  = 1'b0;
        pred_target = inflight_pc + 32'd4;
        if (ret_word[31:27] == 5'b00001) begin
            pred_taken  = 1'b1;
            pred_target = {4'b0000, ret_word[25:0], 2'b00};
        end else if (ret_word[31:26] == 6'b110010) begin
            pred_taken  = 1'b1;
            pred_target = inflight_pc + {4'b0000, ret_word[25:0], 2'b00};
        end else if ((ret_word[31:27] == 5'b00010) && ret_word[15]) begin
            pred_taken  = 1'b1;
            pred_target = inflight_pc + {{14{1'b1}}, ret_word[15:0], 2'b00};
        end
    end

    // Same-cycle pops are not credited, so a push can never land in a full queue.
    always_comb begin
        occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, inflight};
        ret_taken = inflight && pred_taken;
        issue     = !bus.redirect_valid && !ret_taken && (occupancy < (PW + 2)'(DEPTH));
        push      = inflight && !bus.redirect_valid;
        head_valid = (count != '0);
        pop       = head_valid && bus.out_ready && !bus.redirect_valid;
    end

    assign mem_en        = issue && rstn;
    assign bus.mem_en    = mem_en;
    assign bus.inst_addr = mem_en ? fpc[ADDR_W+1:2] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            fpc      <= bus.redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fpc;
            end
            // A taken prediction blocks issue, so nothing sequential is ever in flight to squash.
            if (ret_taken) begin
                fpc <= pred_target;
            end else if (issue) begin
                fpc <= fpc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]     <= inflight_pc;
            inst_q[wr_ptr]   <= ret_word;
            taken_q[wr_ptr]  <= pred_taken;
            target_q[wr_ptr] <= pred_target;
        end
    end

    // Storage is not reset; gating with head_valid keeps the outputs at zero while empty.
    assign bus.out_valid       = head_valid;
    assign bus.out_pc          = head_valid ? pc_q[rd_ptr]     : '0;
    assign bus.out_inst        = head_valid ? inst_q[rd_ptr]   : '0;
    assign bus.out_pred_taken  = head_valid ? taken_q[rd_ptr]  : 1'b0;
    assign bus.out_pred_target = head_valid ? target_q[rd_ptr] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural BRAM with one-cycle read latency,
// and one task per scenario with hand-computed per-cycle expectations.
module tb_fetch_queue;
    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic rstn;

    fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] bram [256];
    logic [31:0] bram_q;

    always @(posedge clk) begin
        if (bus.mem_en) bram_q <= bram[bus.inst_addr[7:0]];
    end
    assign bus.inst_data = bram_q;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic fill_bram();
        for (int i = 0; i < 256; i++) bram[i] = i + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench two time units into cycle 0 (the first cycle out of reset).
    task automatic reset_dut(input logic ready);
        rstn               = 1'b0;
        bus.out_ready      = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
        n_compared++; if (bus.mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_en: got %0h expected 0", bus.mem_en); end
        n_compared++; if (bus.inst_addr !== 17'h0) begin n_mismatched++; $display("[TB] FAIL reset_inst_addr: got %0h expected 0", bus.inst_addr); end
        n_compared++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_pc_inst: got %0h/%0h expected 0/0", bus.out_pc, bus.out_inst); end
        n_compared++; if (bus.out_pred_taken !== 1'b0 || bus.out_pred_target !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pred: got %0h/%0h expected 0/0", bus.out_pred_taken, bus.out_pred_target); end
    endtask

    task automatic test_sequential();
        fill_bram();
        reset_dut(1'b1);
        n_compared++; if (bus.mem_en !== 1'b1 || bus.inst_addr !== 17'd0) begin n_mismatched++; $display("[TB] FAIL seq_c0_issue: got %0h@%0h expected 1@0", bus.mem_en, bus.inst_addr); end
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL seq_c0_valid: got %0h expected 0", bus.out_valid); end
        step();
        n_compared++; if (bus.out_valid !== 1'b0 || bus.inst_addr !== 17'd1) begin n_mismatched++; $display("[TB] FAIL seq_c1: got valid %0h addr %0h expected 0/1", bus.out_valid, bus.inst_addr); end
        for (int c = 2; c < 10; c++) begin
            step();
            n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (c - 2)) || bus.out_inst !== 32'(c - 1)) begin
                n_mismatched++; $display("[TB] FAIL seq_head_c%0d: got v%0h pc %0h inst %0h expected v1 pc %0h inst %0h", c, bus.out_valid, bus.out_pc, bus.out_inst, 4 * (c - 2), c - 1);
            end
            n_compared++; if (bus.out_pred_taken !== 1'b0 || bus.out_pred_target !== 32'(4 * (c - 2) + 4)) begin
                n_mismatched++; $display("[TB] FAIL seq_pred_c%0d: got %0h/%0h expected 0/%0h", c, bus.out_pred_taken, bus.out_pred_target, 4 * (c - 2) + 4);
            end
        end
    endtask

    task automatic test_jump();
        logic        exp_valid [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_pc    [7] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h40, 32'h44, 32'h48};
        fill_bram();
        bram[2] = 32'h0800_0010;
        reset_dut(1'b1);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            if (c == 3) begin
                n_compared++; if (bus.mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL jump_bubble_mem_en: got %0h expected 0", bus.mem_en); end
            end
            if (c >= 2) begin
                n_compared++; if (bus.out_valid !== exp_valid[c-2]) begin n_mismatched++; $display("[TB] FAIL jump_valid_c%0d: got %0h expected %0h", c, bus.out_valid, exp_valid[c-2]); end
                if (exp_valid[c-2]) begin
                    n_compared++; if (bus.out_pc !== exp_pc[c-2]) begin n_mismatched++; $display("[TB] FAIL jump_pc_c%0d: got %0h expected %0h", c, bus.out_pc, exp_pc[c-2]); end
                end
            end
            if (c == 4) begin
                n_compared++; if (bus.out_pred_taken !== 1'b1 || bus.out_pred_target !== 32'h40) begin n_mismatched++; $display("[TB] FAIL jump_pred: got %0h/%0h expected 1/40", bus.out_pred_taken, bus.out_pred_target); end
            end
            if (c == 6) begin
                n_compared++; if (bus.out_inst !== 32'd17) begin n_mismatched++; $display("[TB] FAIL jump_target_inst: got %0h expected 11", bus.out_inst); end
            end
        end
    endtask

    task automatic test_branch(input logic [31:0] word, input logic exp_taken, input logic [31:0] exp_target);
        fill_bram();
        bram[5] = word;
        reset_dut(1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            if (c == 6) begin
                n_compared++; if (bus.mem_en !== !exp_taken) begin n_mismatched++; $display("[TB] FAIL br_mem_en_c6: got %0h expected %0h", bus.mem_en, !exp_taken); end
            end
            if (c == 7) begin
                n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h14 || bus.out_inst !== word) begin n_mismatched++; $display("[TB] FAIL br_head: got v%0h pc %0h inst %0h expected v1 pc 14 inst %0h", bus.out_valid, bus.out_pc, bus.out_inst, word); end
                n_compared++; if (bus.out_pred_taken !== exp_taken || bus.out_pred_target !== exp_target) begin n_mismatched++; $display("[TB] FAIL br_pred: got %0h/%0h expected %0h/%0h", bus.out_pred_taken, bus.out_pred_target, exp_taken, exp_target); end
            end
            if (c == 8) begin
                n_compared++; if (bus.out_valid !== !exp_taken) begin n_mismatched++; $display("[TB] FAIL br_valid_c8: got %0h expected %0h", bus.out_valid, !exp_taken); end
                if (!exp_taken) begin
                    n_compared++; if (bus.out_pc !== 32'h18) begin n_mismatched++; $display("[TB] FAIL br_pc_c8: got %0h expected 18", bus.out_pc); end
                end
            end
            if (c == 9) begin
                n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== (exp_taken ? exp_target : 32'h1C)) begin n_mismatched++; $display("[TB] FAIL br_pc_c9: got v%0h pc %0h expected v1 pc %0h", bus.out_valid, bus.out_pc, exp_taken ? exp_target : 32'h1C); end
            end
        end
    endtask

    task automatic test_stall();
        int issues = 0;
        logic [31:0] exp_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        fill_bram();
        reset_dut(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            if (bus.mem_en === 1'b1) issues++;
            n_compared++; if (bus.mem_en !== (c < 4)) begin n_mismatched++; $display("[TB] FAIL stall_mem_en_c%0d: got %0h expected %0h", c, bus.mem_en, c < 4); end
            if (c >= 2) begin
                n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL stall_head_c%0d: got v%0h pc %0h expected v1 pc 0", c, bus.out_valid, bus.out_pc); end
            end
        end
        n_compared++; if (issues !== 4) begin n_mismatched++; $display("[TB] FAIL stall_issue_count: got %0d expected 4", issues); end
        for (int c = 10; c < 16; c++) begin
            step();
            if (c == 10) begin
                bus.out_ready = 1'b1;
                #1;
                n_compared++; if (bus.mem_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_no_credit: got %0h expected 0", bus.mem_en); end
            end
            if (c == 11) begin
                n_compared++; if (bus.mem_en !== 1'b1 || bus.inst_addr !== 17'd4) begin n_mismatched++; $display("[TB] FAIL stall_resume: got %0h@%0h expected 1@4", bus.mem_en, bus.inst_addr); end
            end
            n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[c-10]) begin n_mismatched++; $display("[TB] FAIL drain_pc_c%0d: got v%0h pc %0h expected v1 pc %0h", c, bus.out_valid, bus.out_pc, exp_pc[c-10]); end
        end
    endtask

    task automatic test_redirect();
        fill_bram();
        reset_dut(1'b0);
        repeat (4) step();
        n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL redir_pre_head: got v%0h pc %0h expected v1 pc 0", bus.out_valid, bus.out_pc); end
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL redir_flush_r1: got %0h expected 0", bus.out_valid); end
        n_compared++; if (bus.mem_en !== 1'b1 || bus.inst_addr !== 17'h40) begin n_mismatched++; $display("[TB] FAIL redir_issue_r1: got %0h@%0h expected 1@40", bus.mem_en, bus.inst_addr); end
        step();
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL redir_valid_r2: got %0h expected 0", bus.out_valid); end
        step();
        n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_inst !== 32'd65) begin n_mismatched++; $display("[TB] FAIL redir_head_r3: got v%0h pc %0h inst %0h expected v1 pc 100 inst 41", bus.out_valid, bus.out_pc, bus.out_inst); end
        step();
        n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin n_mismatched++; $display("[TB] FAIL redir_head_r4: got v%0h pc %0h expected v1 pc 104", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_nop_and_async_reset();
        fill_bram();
        bram[3] = 32'hffff_ffff;
        reset_dut(1'b1);
        repeat (5) step();
        n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hC || bus.out_inst !== 32'h0) begin n_mismatched++; $display("[TB] FAIL nop_head: got v%0h pc %0h inst %0h expected v1 pc c inst 0", bus.out_valid, bus.out_pc, bus.out_inst); end
        n_compared++; if (bus.out_pred_taken !== 1'b0 || bus.out_pred_target !== 32'h10) begin n_mismatched++; $display("[TB] FAIL nop_pred: got %0h/%0h expected 0/10", bus.out_pred_taken, bus.out_pred_target); end
        step();
        rstn = 1'b0;
        #1;
        n_compared++; if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.out_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL async_reset: got v%0h en %0h pc %0h expected 0/0/0", bus.out_valid, bus.mem_en, bus.out_pc); end
        @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        n_compared++; if (bus.mem_en !== 1'b1 || bus.inst_addr !== 17'd0) begin n_mismatched++; $display("[TB] FAIL restart_issue: got %0h@%0h expected 1@0", bus.mem_en, bus.inst_addr); end
        step();
        step();
        n_compared++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'd1) begin n_mismatched++; $display("[TB] FAIL restart_head: got v%0h pc %0h inst %0h expected v1 pc 0 inst 1", bus.out_valid, bus.out_pc, bus.out_inst); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch(32'h1000_FFFE, 1'b1, 32'h0000_000C);
        test_branch(32'h1000_0002, 1'b0, 32'h0000_0018);
        test_stall();
        test_redirect();
        test_nop_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
